// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: register file geometry, reset level and helpers shared by the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int RegNumLog2 = 5;
  localparam int RegNum = 32;
  localparam int RegWidth = 32;
  typedef logic [RegNumLog2-1:0] RegAddrBus;
  typedef logic [RegWidth-1:0] RegBus;
  localparam logic RstEnable = 1'b0;
  localparam RegBus ZeroWord = '0;
  function automatic int ptr_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests, regfile write port, and issue-stage scoreboard signals
// slave = arbiter side, master = requesters/issue stage/regfile side.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_W = RegNumLog2,
  parameter int DATA_W = RegWidth,
  parameter int NREG = RegNum
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic alloc_valid;
  logic [ADDR_W-1:0] alloc_addr;
  logic alloc_ready;
  logic [NREG-1:0] busy;
  modport slave(
    input req_valid, req_addr, req_data, alloc_valid, alloc_addr,
    output req_ready, we, waddr, wdata, alloc_ready, busy
  );
  modport master(
    output req_valid, req_addr, req_data, alloc_valid, alloc_addr,
    input req_ready, we, waddr, wdata, alloc_ready, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid index at or after rr_ptr
// valid/rr_ptr in; one-hot gnt and its index gnt_idx out (both zero when nothing is valid).
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PTR_W = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] gnt_idx
);
  // Scan from farthest to nearest so the nearest valid index overwrites earlier hits.
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid[(int'(rr_ptr) + k) % NREQ]) begin
        gnt_idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
        gnt = NREQ'(1) << gnt_idx;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the regfile write port plus a pending-write scoreboard
// clk, rst (async, active-low), bus: requester handshake, registered we/waddr/wdata, alloc_* and busy.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_W = RegNumLog2,
  parameter int DATA_W = RegWidth,
  parameter int NREG = RegNum
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PTR_W = ptr_w(NREQ);
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic xfer, alloc_fire;
  logic [ADDR_W-1:0] sel_addr, waddr_q, waddr_d;
  logic [DATA_W-1:0] sel_data, wdata_q, wdata_d;
  logic we_q, we_d;
  logic [NREG-1:0] busy_q, busy_d;
  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
    .valid(bus.req_valid),
    .rr_ptr(rr_ptr_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  assign bus.req_ready = gnt;
  assign bus.we = we_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.busy = busy_q;
  // A register being written this cycle is visible through the regfile bypass, so it may be re-claimed.
  assign bus.alloc_ready = !busy_q[bus.alloc_addr] || (we_q && waddr_q == bus.alloc_addr) || bus.alloc_addr == '0;
  always_comb begin
    xfer = |gnt;
    sel_addr = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_data = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    rr_ptr_d = !xfer ? rr_ptr_q : (int'(gnt_idx) == NREQ - 1 ? '0 : gnt_idx + 1'b1);
    we_d = xfer && sel_addr != '0;
    waddr_d = we_d ? sel_addr : waddr_q;
    wdata_d = we_d ? sel_data : wdata_q;
    alloc_fire = bus.alloc_valid && bus.alloc_ready && bus.alloc_addr != '0;
    busy_d = busy_q;
    if (we_q) busy_d[waddr_q] = 1'b0;
    if (alloc_fire) busy_d[bus.alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      rr_ptr_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= DATA_W'(ZeroWord);
      busy_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table vectors, directed corner sequences and random traffic against a reference model
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  regfile_wb_arbiter_if #(.NREQ(2)) bus ();
  regfile_wb_arbiter #(.NREQ(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  int passes = 0;
  int total = 0;
  int m_ptr;
  bit m_we;
  logic [4:0] m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_busy;
  typedef struct {
    bit v0, v1;
    logic [4:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0] rdy;
    bit we;
    logic [4:0] waddr;
    logic [31:0] wdata;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic drive(bit v0, bit v1, logic [4:0] a0, logic [4:0] a1, logic [31:0] d0, logic [31:0] d1, bit av, logic [4:0] aa);
    bus.req_valid = {v1, v0};
    bus.req_addr = {a1, a0};
    bus.req_data = {d1, d0};
    bus.alloc_valid = av;
    bus.alloc_addr = aa;
  endtask
  task automatic model_reset();
    m_ptr = 0;
    m_we = 0;
    m_waddr = '0;
    m_wdata = '0;
    m_busy = '0;
  endtask
  // Called at posedge+1 with inputs already driven; checks combinational and then registered outputs.
  task automatic cycle(output logic [1:0] rdy, output logic ar);
    int g;
    bit ea;
    logic [31:0] nb;
    logic [4:0] a;
    #2;
    g = -1;
    for (int k = 0; k < 2; k++) if (bus.req_valid[(m_ptr + k) % 2] && g < 0) g = (m_ptr + k) % 2;
    ea = !m_busy[bus.alloc_addr] || (m_we && m_waddr == bus.alloc_addr) || bus.alloc_addr == 0;
    rdy = bus.req_ready;
    ar = bus.alloc_ready;
    chk("req_ready", 32'(bus.req_ready), g < 0 ? 0 : 1 << g);
    chk("alloc_ready", 32'(bus.alloc_ready), 32'(ea));
    nb = m_busy;
    if (m_we) nb[m_waddr] = 1'b0;
    if (bus.alloc_valid && ea && bus.alloc_addr != 0) nb[bus.alloc_addr] = 1'b1;
    nb[0] = 1'b0;
    if (g >= 0) begin
      a = bus.req_addr[g*5 +: 5];
      m_we = a != 0;
      if (a != 0) begin
        m_waddr = a;
        m_wdata = bus.req_data[g*32 +: 32];
      end
      m_ptr = (g + 1) % 2;
    end else m_we = 0;
    m_busy = nb;
    @(posedge clk);
    #1;
    chk("we", 32'(bus.we), 32'(m_we));
    chk("waddr", 32'(bus.waddr), 32'(m_waddr));
    chk("wdata", bus.wdata, m_wdata);
    chk("busy", bus.busy, m_busy);
  endtask
  initial begin
    logic [1:0] r;
    logic ar;
    bit ok;
    tbl[0] = '{1, 0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b01, 1, 5'd5, 32'hDEADBEEF};
    tbl[1] = '{0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 0, 5'd5, 32'hDEADBEEF};
    tbl[2] = '{0, 1, 5'd0, 5'd0, 32'h0, 32'h1234, 2'b10, 0, 5'd5, 32'hDEADBEEF};
    tbl[3] = '{0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 0, 5'd5, 32'hDEADBEEF};
    tbl[4] = '{1, 1, 5'd1, 5'd2, 32'h11, 32'h22, 2'b01, 1, 5'd1, 32'h11};
    tbl[5] = '{1, 1, 5'd1, 5'd2, 32'h11, 32'h22, 2'b10, 1, 5'd2, 32'h22};
    tbl[6] = '{1, 1, 5'd1, 5'd2, 32'h11, 32'h22, 2'b01, 1, 5'd1, 32'h11};
    tbl[7] = '{1, 1, 5'd1, 5'd2, 32'h11, 32'h22, 2'b10, 1, 5'd2, 32'h22};
    tbl[8] = '{0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 0, 5'd2, 32'h22};
    drive(1, 1, 5'd3, 5'd4, $urandom, $urandom, 1, 5'd9);
    #3;
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_waddr", 32'(bus.waddr), 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      drive(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, 1, 5'($urandom));
    end
    chk("rst_hold_we", 32'(bus.we), 0);
    chk("rst_hold_busy", bus.busy, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, 0, 0);
      cycle(r, ar);
      chk($sformatf("tbl%0d_ready", i), 32'(r), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_we", i), 32'(bus.we), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_waddr", i), 32'(bus.waddr), 32'(tbl[i].waddr));
      chk($sformatf("tbl%0d_wdata", i), bus.wdata, tbl[i].wdata);
      chk($sformatf("tbl%0d_busy0", i), 32'(bus.busy[0]), 0);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
    cycle(r, ar);
    chk("sb_alloc_ready", 32'(ar), 1);
    chk("sb_set7", 32'(bus.busy[7]), 1);
    cycle(r, ar);
    chk("sb_realloc_blocked", 32'(ar), 0);
    chk("sb_still7", 32'(bus.busy[7]), 1);
    drive(1, 0, 5'd7, 0, 32'h77, 0, 0, 5'd7);
    cycle(r, ar);
    chk("sb_wb_we", 32'(bus.we), 1);
    chk("sb_wb_waddr", 32'(bus.waddr), 7);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
    cycle(r, ar);
    chk("sb_bypass_ready", 32'(ar), 1);
    chk("sb_set_wins", 32'(bus.busy[7]), 1);
    drive(1, 0, 5'd7, 0, 32'h78, 0, 0, 5'd7);
    cycle(r, ar);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd7);
    cycle(r, ar);
    chk("sb_wb_ready", 32'(ar), 1);
    chk("sb_cleared", 32'(bus.busy[7]), 0);
    repeat (6) begin
      drive(1, 0, 5'($urandom_range(1, 31)), 5'd9, $urandom, $urandom, 0, 0);
      repeat ($urandom_range(1, 3)) cycle(r, ar);
      bus.req_valid[1] = 1'b1;
      ok = 0;
      for (int c = 0; c < 2 && !ok; c++) begin
        cycle(r, ar);
        ok = r[1];
      end
      chk("fair_req1", 32'(ok), 1);
    end
    repeat (400) begin
      drive(1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
            1'($urandom), 5'($urandom_range(0, 7)));
      cycle(r, ar);
    end
    drive(1, 1, 5'd3, 5'd4, 32'hAAAA5555, 32'h5555AAAA, 1, 5'd3);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_we", 32'(bus.we), 0);
    chk("midrst_waddr", 32'(bus.waddr), 0);
    chk("midrst_wdata", bus.wdata, 0);
    chk("midrst_busy", bus.busy, 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) cycle(r, ar);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (we/waddr/wdata) among NREQ writeback requesters, e.g. ALU result and load result.
- Round-robin grant with valid/ready handshake; one registered output stage drives the register file.
- Keeps a 32-entry pending-write scoreboard (busy bits) so the issue stage can stall on RAW/WAW hazards against in-flight writes.
- Sits between the writeback sources and regfile; the issue/decode stage uses alloc_* and busy.

Parameters:
- NREQ, 2, number of writeback requesters (2..4)
- ADDR_W, 5, register address width (RegNumLog2)
- DATA_W, 32, register data width (RegBus)
- NREG, 32, number of architectural registers (RegNum)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset; 0 = reset asserted
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  requester i granted this cycle; combinational
- req_addr  in  NREQ*ADDR_W  destination of requester i, slice [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  data of requester i, slice [i*DATA_W +: DATA_W]
- we  out  1  register file write enable; registered
- waddr  out  ADDR_W  register file write address; registered
- wdata  out  DATA_W  register file write data; registered
- alloc_valid  in  1  issue stage claims destination alloc_addr
- alloc_addr  in  ADDR_W  destination being claimed
- alloc_ready  out  1  claim accepted this cycle; combinational
- busy  out  NREG  pending-write bit per register; registered; busy[0] is always 0

Behaviour:
- Reset (rst=0, asynchronous): we=0, waddr=0, wdata=0, rr_ptr=0, busy=0. A request granted but not yet written is dropped. Outputs leave reset on the first clk edge after rst=1.
- Grant:
  - Among requesters with req_valid=1, grant the first index at or after rr_ptr, wrapping modulo NREQ.
  - At most one req_ready bit is high, in the same cycle as its valid; a transfer happens when valid&ready.
  - On a transfer, rr_ptr <= (grant+1) mod NREQ; otherwise rr_ptr holds.
  - req_ready never asserts without the matching req_valid.
- Output stage, latency exactly 1 cycle:
  - On a transfer with addr!=0: we<=1, waddr<=addr, wdata<=data at the next edge.
  - On a transfer with addr==0: the request is consumed (ready=1) but we<=0.
  - With no transfer: we<=0, and waddr/wdata hold their previous values.
  - Back-to-back grants give one write per cycle. Throughput is 1 write/cycle total.
- Scoreboard:
  - Set: alloc_valid & alloc_ready & alloc_addr!=0 sets busy[alloc_addr] at the edge.
  - Clear: a cycle with we=1 clears busy[waddr] at the end of that cycle. The regfile's same-cycle write-to-read bypass makes the data visible that cycle.
  - Same address set and cleared at the same edge: set wins, so busy stays 1.
  - alloc_ready = !busy[alloc_addr] | (we & waddr==alloc_addr) | (alloc_addr==0).
  - alloc_valid with alloc_ready=0: no state change; the issue stage must hold the request.
  - Clearing a register that is not busy is harmless; busy stays 0.
- Width rules: no arithmetic beyond the pointer increment and wrap. rr_ptr width is clog2(NREQ), minimum 1.

Decomposition:
- Shared package/defines: ADDR_W/DATA_W/NREG via the existing RegAddrBus, RegBus, RegNum, RegNumLog2; rst-asserted level constant; ZeroWord.
- Sub-module rr_arbiter (NREQ parameter): inputs valid vector and rr_ptr, outputs one-hot grant and grant index; combinational. Reusable by later shared-port controllers.
- Scoreboard stays inline (about 30 lines).

Test Plan:
- Reset: hold rst=0 with random inputs -> we=0, waddr=0, wdata=0, busy=0. Drop rst mid-burst -> the pending write never appears.
- Single request: req0 addr=5, data=0xDEADBEEF -> req_ready=2'b01 the same cycle; next cycle we=1, waddr=5, wdata=0xDEADBEEF; the following cycle we=0.
- Contention: both valid for 4 cycles (req0 addr=1, req1 addr=2) -> grants 0,1,0,1; waddr sequence 1,2,1,2 with one cycle lag; no idle cycles.
- x0 write: req1 addr=0, data=0x1234 -> req_ready[1]=1; we stays 0 next cycle; busy[0] stays 0.
- Scoreboard:
  - alloc addr=7 -> busy[7]=1.
  - A second alloc of 7 -> alloc_ready=0.
  - Writeback to 7 -> in the we=1 cycle alloc_ready=1 for 7; busy[7] stays 1 if re-allocated that cycle, else clears to 0.
- Fairness: req0 held valid continuously, req1 pulses valid -> req1 is granted within 2 cycles of asserting valid, every time.
